req_fifo_reader: RTL and testbench

//  Downstream drain stage for the request FIFO. Issues pops against its 1-cycle-latency

---
 rtl/req_pkg.sv | 14 +
 rtl/req_skid_buf.sv | 38 +++
 rtl/req_fifo_reader.sv | 68 ++++++
 tb/tb_req_fifo_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/req_pkg.sv
// req_pkg: request-path widths, beat type and skid occupancy helper shared by the FIFO, reader and TX encoder
package req_pkg;
  localparam int REQ_WIDTH = 64;
  localparam int SEQ_W = 8;
  localparam int OCC_W = 2;
  typedef struct packed {
    logic [REQ_WIDTH-1:0] data;
    logic [SEQ_W-1:0]     seq;
  } req_beat_t;
  function automatic logic [OCC_W-1:0] occ_next(input logic [OCC_W-1:0] occ, input logic push,
                                                input logic pop);
    return occ + OCC_W'(push) - OCC_W'(pop);
  endfunction
endpackage

// File: rtl/req_skid_buf.sv
// req_skid_buf: 2-entry register skid buffer; entry 0 is always the head
module req_skid_buf import req_pkg::*; #(
  parameter int W = 72
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     head,
  output logic [OCC_W-1:0] occ
);
  logic [W-1:0]     ent0_q, ent0_d, ent1_q, ent1_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             pop_ok, push_ok, wr_slot;
  always_comb begin
    pop_ok = pop & (occ_q != '0);
    push_ok = push & ((occ_q != OCC_W'(2)) | pop_ok);
    // the incoming word lands in the first free slot after this cycle's pop shifts the queue
    wr_slot = (occ_q - OCC_W'(pop_ok)) != '0;
    ent0_d = (push_ok & ~wr_slot) ? din : pop_ok ? ent1_q : ent0_q;
    ent1_d = (push_ok & wr_slot) ? din : ent1_q;
    occ_d = occ_next(occ_q, push_ok, pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q <= occ_d;
    end
  end
  assign head = ent0_q;
  assign occ = occ_q;
endmodule

// File: rtl/req_fifo_reader.sv
// req_fifo_reader: drains the request FIFO through a 2-entry skid buffer onto a valid/ready port with sequence tags
module req_fifo_reader #(
  parameter int WIDTH = req_pkg::REQ_WIDTH,
  parameter int SEQ_W = req_pkg::SEQ_W,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_r_data,
  input  logic             fifo_r_data_valid,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [SEQ_W-1:0] m_seq,
  output logic             busy,
  output logic             err_unexpected,
  output logic [CNT_W-1:0] deliv_cnt
);
  import req_pkg::*;
  localparam int BW = WIDTH + SEQ_W;
  logic             inflight_q, inflight_d, err_q, err_d, push, pop;
  logic [SEQ_W-1:0] tag_q, tag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ;
  logic [OCC_W:0]   pending;
  logic [BW-1:0]    head;
  req_skid_buf #(.W(BW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({fifo_r_data, tag_q}),
    .head  (head),
    .occ   (occ)
  );
  always_comb begin
    m_valid = occ != '0;
    {m_data, m_seq} = head;
    pop = m_valid & m_ready;
    push = fifo_r_data_valid & inflight_q;
    // a new read is safe only if the skid still has room once the in-flight word lands
    pending = {1'b0, occ} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
    fifo_rd = en & ~fifo_empty & ~reset & (pending < (OCC_W+1)'(2));
    inflight_d = fifo_rd;
    err_d = err_q | (fifo_r_data_valid & ~inflight_q);
    tag_d = push ? tag_q + SEQ_W'(1) : tag_q;
    cnt_d = pop ? cnt_q + CNT_W'(1) : cnt_q;
    busy = m_valid | inflight_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      err_q <= 1'b0;
      tag_q <= '0;
      cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q <= err_d;
      tag_q <= tag_d;
      cnt_q <= cnt_d;
    end
  end
  assign err_unexpected = err_q;
  assign deliv_cnt = cnt_q;
endmodule

// File: tb/tb_req_fifo_reader.sv
// tb_req_fifo_reader: FIFO models feed two readers (default and 2-bit tags); a negedge monitor scores every beat
module tb_req_fifo_reader;
  import req_pkg::*;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  int total = 0, bad = 0, rd_cnt = 0, rd2_cnt = 0, rd0 = 0, n = 0;
  logic        en = 0, m_ready = 0, inj_vld = 0, wr_en = 0, fifo_empty = 1, f_vld = 0;
  logic [63:0] wr_data = '0, f_data = '0, m_data;
  logic        fifo_rd, m_valid, busy, err_unexpected;
  logic [7:0]  m_seq, sb_seq = 0;
  logic [31:0] deliv_cnt;
  logic        en2 = 0, m_ready2 = 0, wr2_en = 0, fifo_empty2 = 1, f_vld2 = 0;
  logic [63:0] wr2_data = '0, f_data2 = '0, m_data2;
  logic        fifo_rd2, m_valid2, busy2, err2;
  logic [1:0]  m_seq2, sb_seq2 = 0;
  logic [31:0] deliv_cnt2;
  logic [63:0] fq[$], fq2[$];
  req_beat_t   expq[$], expq2[$];
  req_beat_t   e1, e2;
  req_fifo_reader dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_r_data(f_data), .fifo_r_data_valid(f_vld | inj_vld), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_seq(m_seq), .busy(busy),
    .err_unexpected(err_unexpected), .deliv_cnt(deliv_cnt)
  );
  req_fifo_reader #(.SEQ_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .fifo_empty(fifo_empty2), .fifo_rd(fifo_rd2),
    .fifo_r_data(f_data2), .fifo_r_data_valid(f_vld2), .m_valid(m_valid2),
    .m_ready(m_ready2), .m_data(m_data2), .m_seq(m_seq2), .busy(busy2),
    .err_unexpected(err2), .deliv_cnt(deliv_cnt2)
  );
  // FIFO models: 1-cycle read latency, refuse reads when empty, cleared by the shared reset
  always @(posedge clk) begin
    if (reset) begin
      fq.delete(); fq2.delete();
      f_vld <= 0; f_vld2 <= 0; fifo_empty <= 1; fifo_empty2 <= 1;
    end else begin
      f_vld <= fifo_rd && fq.size() > 0;
      if (fifo_rd && fq.size() > 0) f_data <= fq.pop_front();
      if (wr_en) fq.push_back(wr_data);
      fifo_empty <= fq.size() == 0;
      f_vld2 <= fifo_rd2 && fq2.size() > 0;
      if (fifo_rd2 && fq2.size() > 0) f_data2 <= fq2.pop_front();
      if (wr2_en) fq2.push_back(wr2_data);
      fifo_empty2 <= fq2.size() == 0;
    end
  end
  always @(negedge clk) begin
    if (fifo_rd) rd_cnt++;
    if (fifo_rd2) rd2_cnt++;
    if (fifo_empty || !en) begin
      total++;
      if (fifo_rd) begin bad++; $display("FAIL rd_guard: fifo_rd=1 required 0 (empty=%0b en=%0b) t=%0t", fifo_empty, en, $time); end
    end
    if (fifo_empty2 || !en2) begin
      total++;
      if (fifo_rd2) begin bad++; $display("FAIL rd_guard2: fifo_rd=1 required 0 (empty=%0b en=%0b) t=%0t", fifo_empty2, en2, $time); end
    end
    if (!reset && m_valid && m_ready) begin
      total++;
      if (expq.size() == 0) begin bad++; $display("FAIL beat_extra: got data=%0h seq=%0d, required no beat", m_data, m_seq); end
      else begin
        e1 = expq.pop_front();
        if (m_data !== e1.data || m_seq !== e1.seq) begin
          bad++; $display("FAIL beat: got data=%0h seq=%0d required data=%0h seq=%0d", m_data, m_seq, e1.data, e1.seq);
        end
      end
    end
    if (!reset && m_valid2 && m_ready2) begin
      total++;
      if (expq2.size() == 0) begin bad++; $display("FAIL beat2_extra: got data=%0h seq=%0d, required no beat", m_data2, m_seq2); end
      else begin
        e2 = expq2.pop_front();
        if (m_data2 !== e2.data || {6'b0, m_seq2} !== e2.seq) begin
          bad++; $display("FAIL beat2: got data=%0h seq=%0d required data=%0h seq=%0d", m_data2, m_seq2, e2.data, e2.seq);
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp); end
  endtask
  task automatic wr(input logic [63:0] d);
    wr_data = d; wr_en = 1; expq.push_back('{d, sb_seq}); sb_seq++;
    tick(); wr_en = 0;
  endtask
  task automatic wr2(input logic [63:0] d);
    wr2_data = d; wr2_en = 1; expq2.push_back('{d, {6'b0, sb_seq2}}); sb_seq2++;
    tick(); wr2_en = 0;
  endtask
  task automatic drain(input string name);
    int k = 0;
    while ((expq.size() != 0 || m_valid) && k < 60) begin tick(); k++; end
    chk(name, 64'(expq.size() == 0 && !m_valid), 1);
  endtask
  task automatic drain2(input string name);
    int k = 0;
    while ((expq2.size() != 0 || m_valid2) && k < 60) begin tick(); k++; end
    chk(name, 64'(expq2.size() == 0 && !m_valid2), 1);
  endtask
  task automatic do_reset();
    reset = 1; tick(); reset = 0;
    expq.delete(); expq2.delete(); sb_seq = 0; sb_seq2 = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) tick();
    reset = 0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0); chk("rst_m_data", m_data, 0); chk("rst_m_seq", m_seq, 0);
    chk("rst_fifo_rd", fifo_rd, 0); chk("rst_busy", busy, 0); chk("rst_err", err_unexpected, 0);
    chk("rst_deliv", deliv_cnt, 0);
    // streaming at one request per cycle
    m_ready = 1; m_ready2 = 1;
    for (int i = 1; i <= 16; i++) wr(64'(i));
    en = 1; rd0 = rd_cnt; n = 0;
    @(negedge clk);
    while (!m_valid && n < 10) begin @(negedge clk); n++; end
    chk("stream_start", m_valid, 1);
    for (int i = 0; i < 16; i++) begin chk("stream_valid", m_valid, 1); @(negedge clk); end
    chk("stream_cnt", deliv_cnt, 16); chk("stream_idle", m_valid, 0);
    tick(); chk("stream_rd", 64'(rd_cnt - rd0), 16);
    // backpressure
    en = 0; m_ready = 0;
    for (int i = 1; i <= 8; i++) wr(64'(i));
    en = 1; rd0 = rd_cnt;
    repeat (10) tick();
    chk("bp_rd", 64'(rd_cnt - rd0), 2);
    @(negedge clk);
    chk("bp_occ", 64'(dut.occ), 2); chk("bp_hold", m_data, 1); chk("bp_valid", m_valid, 1); chk("bp_seq", m_seq, 16);
    tick(); m_ready = 1;
    drain("bp_drain"); chk("bp_cnt", deliv_cnt, 24);
    // empty guard and write-to-valid latency
    wr(64'h31); wr(64'h32); wr(64'h33);
    drain("eg_drain1");
    repeat (4) tick();
    wr(64'h44);
    @(negedge clk); chk("eg_lat1", m_valid, 0);
    @(negedge clk); chk("eg_lat2", m_valid, 0);
    @(negedge clk); chk("eg_lat3", m_valid, 1);
    tick(); drain("eg_drain2");
    // unexpected read data
    en = 0; inj_vld = 1;
    @(negedge clk); chk("err_pre", err_unexpected, 0);
    tick(); inj_vld = 0;
    @(negedge clk); chk("err_set", err_unexpected, 1);
    repeat (3) tick();
    @(negedge clk); chk("err_sticky", err_unexpected, 1); chk("err_mvalid", m_valid, 0); chk("err_drop", 64'(dut.occ), 0);
    tick(); do_reset();
    @(negedge clk); chk("err_clr", err_unexpected, 0);
    // reset with buffered and in-flight words
    tick(); en = 1; m_ready = 1;
    wr(64'hA1); wr(64'hA2);
    drain("mid_pre_drain"); chk("mid_pre_cnt", deliv_cnt, 2);
    en = 0; m_ready = 0;
    for (int i = 0; i < 4; i++) wr(64'h100 + 64'(i));
    en = 1; tick(); tick(); reset = 1;
    @(negedge clk); chk("mid_occ", 64'(dut.occ), 1); chk("mid_inflight", dut.inflight_q, 1);
    tick(); reset = 0;
    expq.delete(); expq2.delete(); sb_seq = 0; sb_seq2 = 0;
    @(negedge clk);
    chk("mid_valid", m_valid, 0); chk("mid_busy", busy, 0); chk("mid_cnt", deliv_cnt, 0); chk("mid_err", err_unexpected, 0);
    tick(); m_ready = 1;
    wr(64'h55); drain("mid_drain");
    // tag wrap at 2 bits with enable gap
    for (int i = 1; i <= 6; i++) wr2(64'h200 + 64'(i));
    en2 = 1; rd0 = rd2_cnt;
    tick(); tick(); tick(); en2 = 0;
    repeat (4) tick();
    @(negedge clk); chk("wrap_mid_cnt", deliv_cnt2, 3);
    tick(); en2 = 1;
    drain2("wrap_drain"); chk("wrap_cnt", deliv_cnt2, 6); chk("wrap_rd", 64'(rd2_cnt - rd0), 6);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
